// File: rtl/sif_modport_pkg.sv
// Shared types for the SIF slave: bus widths, address/data types, op kinds.
// Optional feature macro used by the top level: SIF_WR_COUNT_EN.
package sif_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef logic [ADDR_W-1:0] sif_addr_t;
    typedef logic [DATA_W-1:0] sif_data_t;

    typedef enum logic {
        READ,
        WRITE
    } sif_op_t;

    typedef struct packed {
        sif_op_t   op;
        sif_addr_t addr;
        sif_data_t data;
    } sif_txn_t;

    // Top address of the map, where the optional write counter lives.
    localparam sif_addr_t CNT_ADDR = '1;

endpackage

// File: rtl/sif_modport_if.sv
// XA (host access) and WA (write-around) signal bundle for the SIF slave.
// Master drives XA requests and consumes read data plus forwarded writes.
interface sif_modport_if;
    import sif_pkg::*;

    sif_addr_t xa_addr;
    sif_data_t xa_data_wr;
    logic      xa_wr_s;
    logic      xa_rd_s;
    sif_data_t xa_data_rd;
    sif_addr_t wa_addr;
    sif_data_t wa_data_wr;
    logic      wa_wr_s;

    modport master (
        output xa_addr,
        output xa_data_wr,
        output xa_wr_s,
        output xa_rd_s,
        input  xa_data_rd,
        input  wa_addr,
        input  wa_data_wr,
        input  wa_wr_s
    );

    modport slave (
        input  xa_addr,
        input  xa_data_wr,
        input  xa_wr_s,
        input  xa_rd_s,
        output xa_data_rd,
        output wa_addr,
        output wa_data_wr,
        output wa_wr_s
    );

endinterface

// File: rtl/sif_modport_regfile.sv
// Local register bank: one write port, one registered read-before-write port.
// The read port can load a substitute word for addresses outside the bank.
module sif_regfile
    import sif_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  sif_data_t     wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    input  logic          alt_en,
    input  sif_data_t     alt_data,
    output sif_data_t     rdata
);

    sif_data_t mem [DEPTH];

    // Storage: cleared on reset, otherwise written on an in-range write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: sees pre-write contents, holds value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= alt_en ? alt_data : mem[raddr];
        end
    end

endmodule

// File: rtl/sif_modport.sv
// SIF slave: local register bank on XA, every XA write forwarded on WA.
// Macro SIF_WR_COUNT_EN adds a saturating write counter read at 0xFFFF.
module sif_modport
    import sif_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    sif_modport_if.slave  bus
);

    localparam int IW = $clog2(DEPTH);

    logic          hit;
    logic [IW-1:0] idx;
    sif_data_t     alt_data;

    // Full-width compare: no aliasing of high addresses onto the bank.
    assign hit = bus.xa_addr < sif_addr_t'(DEPTH);
    assign idx = bus.xa_addr[IW-1:0];

`ifdef SIF_WR_COUNT_EN
    logic [15:0] wr_cnt;

    // Count accepted writes, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (bus.xa_wr_s && (wr_cnt != '1)) begin
            wr_cnt <= wr_cnt + 16'd1;
        end
    end

    assign alt_data = (bus.xa_addr == CNT_ADDR) ?
                      sif_data_t'(wr_cnt) : '0;
`else
    assign alt_data = '0;
`endif

    sif_regfile #(
        .DEPTH (DEPTH)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (bus.xa_wr_s & hit),
        .waddr    (idx),
        .wdata    (bus.xa_data_wr),
        .re       (bus.xa_rd_s),
        .raddr    (idx),
        .alt_en   (~hit),
        .alt_data (alt_data),
        .rdata    (bus.xa_data_rd)
    );

    // Write-around: one-cycle strobe, address/data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wa_wr_s    <= 1'b0;
            bus.wa_addr    <= '0;
            bus.wa_data_wr <= '0;
        end else begin
            bus.wa_wr_s <= bus.xa_wr_s;
            if (bus.xa_wr_s) begin
                bus.wa_addr    <= bus.xa_addr;
                bus.wa_data_wr <= bus.xa_data_wr;
            end
        end
    end

endmodule

// File: tb/tb_sif_modport.sv
// Scoreboard bench for sif_modport: driver queues expected responses,
// monitor pops and compares on every WA pulse and every read return.
module tb_sif_modport;
    import sif_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sif_modport_if bus ();

    sif_modport #(
        .DEPTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wa_q [$];
    logic [15:0] rd_q [$];
    logic [15:0] mdl [16];
    int          cnt = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        if (a < 16'd16) return mdl[a[3:0]];
`ifdef SIF_WR_COUNT_EN
        if (a == 16'hFFFF) return 16'(cnt);
`endif
        return 16'h0000;
    endfunction

    task automatic cyc(input logic wr, input logic rd,
                       input logic [15:0] a,
                       input logic [15:0] d);
        sif_txn_t t;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.xa_wr_s    = wr;
        bus.xa_rd_s    = rd;
        bus.xa_addr    = a;
        bus.xa_data_wr = d;
        if (rd) rd_q.push_back(model_rd(a));
        if (wr) begin
            t = '{op: WRITE, addr: a, data: d};
            wa_q.push_back({t.addr, t.data});
            if (a < 16'd16) mdl[a[3:0]] = d;
            if (cnt < 16'hFFFF) cnt++;
        end
    endtask

    // Reset for n cycles; first reset cycle also carries live strobes.
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst            = 1'b1;
        bus.xa_wr_s    = 1'b1;
        bus.xa_rd_s    = 1'b1;
        bus.xa_addr    = 16'h0007;
        bus.xa_data_wr = 16'h7777;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        cnt = 0;
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.xa_wr_s = 1'b0;
            bus.xa_rd_s = 1'b0;
        end
    endtask

    // Monitor: capture strobes at the edge, compare at the negedge.
    initial begin
        logic        rd_seen;
        logic        rs;
        logic [31:0] e;
        logic [15:0] last_a  = '0;
        logic [15:0] last_d  = '0;
        logic [15:0] last_rd = '0;
        forever begin
            @(posedge clk);
            rd_seen = bus.xa_rd_s && !rst;
            rs      = rst;
            @(negedge clk);
            if (rs) begin
                chk("rst_wa_wr_s", 32'(bus.wa_wr_s), 0);
                chk("rst_wa_addr", 32'(bus.wa_addr), 0);
                chk("rst_wa_data", 32'(bus.wa_data_wr), 0);
                chk("rst_rd_data", 32'(bus.xa_data_rd), 0);
                last_a  = '0;
                last_d  = '0;
                last_rd = '0;
            end else begin
                if (bus.wa_wr_s) begin
                    if (wa_q.size() == 0) begin
                        chk("wa_unexpected", 1, 0);
                    end else begin
                        e = wa_q.pop_front();
                        chk("wa_addr", 32'(bus.wa_addr),
                            32'(e[31:16]));
                        chk("wa_data", 32'(bus.wa_data_wr),
                            32'(e[15:0]));
                        last_a = e[31:16];
                        last_d = e[15:0];
                    end
                end else begin
                    chk("wa_hold_addr", 32'(bus.wa_addr),
                        32'(last_a));
                    chk("wa_hold_data", 32'(bus.wa_data_wr),
                        32'(last_d));
                end
                if (rd_seen) begin
                    if (rd_q.size() == 0) begin
                        chk("rd_unexpected", 1, 0);
                    end else begin
                        last_rd = rd_q.pop_front();
                        chk("rd_data", 32'(bus.xa_data_rd),
                            32'(last_rd));
                    end
                end else begin
                    chk("rd_hold", 32'(bus.xa_data_rd),
                        32'(last_rd));
                end
            end
        end
    end

    initial begin
        bus.xa_wr_s    = 1'b0;
        bus.xa_rd_s    = 1'b0;
        bus.xa_addr    = '0;
        bus.xa_data_wr = '0;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("init_wa_wr_s", 32'(bus.wa_wr_s), 0);
        chk("init_rd_data", 32'(bus.xa_data_rd), 0);

        cyc(1'b0, 1'b1, 16'h0003, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0005, 16'hBEEF);
        cyc(1'b0, 1'b1, 16'h0005, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0001, 16'h1111);
        cyc(1'b1, 1'b0, 16'h0002, 16'h2222);
        cyc(1'b1, 1'b0, 16'h0100, 16'hCAFE);
        cyc(1'b0, 1'b1, 16'h0100, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0004, 16'h0A0A);
        cyc(1'b1, 1'b1, 16'h0004, 16'hB0B0);
        cyc(1'b0, 1'b1, 16'h0004, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0010, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);

        cyc(1'b1, 1'b0, 16'h0006, 16'h6666);
        do_reset(2);
        cyc(1'b0, 1'b1, 16'h0006, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0007, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0005, 16'h0000);

        cyc(1'b1, 1'b0, 16'h0008, 16'h0808);
        cyc(1'b1, 1'b0, 16'h0009, 16'h0909);
        cyc(1'b1, 1'b0, 16'h000F, 16'h0F0F);
        cyc(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        cyc(1'b0, 1'b1, 16'h000F, 16'h0000);

        repeat (4) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        chk("wa_q_drained", 32'(wa_q.size()), 0);
        chk("rd_q_drained", 32'(rd_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
